// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the fmul/fdiv family: field extraction,
// bias, special-value constants, flag bit positions and the divider state enum.
package fp_pkg;

  localparam int unsigned FP_MAX_W = 64;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned FLAG_INV = 3;
  localparam int unsigned FLAG_DZ  = 2;
  localparam int unsigned FLAG_OF  = 1;
  localparam int unsigned FLAG_UF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fdiv_state_e;

  function automatic fp_word_t fp_mask(input int unsigned n);
    if (n >= FP_MAX_W) return '1;
    return (fp_word_t'(1) << n) - fp_word_t'(1);
  endfunction

  function automatic fp_word_t fp_frac_of(input fp_word_t x, input int unsigned fw);
    return x & fp_mask(fw);
  endfunction

  function automatic fp_word_t fp_exp_of(input fp_word_t x, input int unsigned ew,
                                         input int unsigned fw);
    return (x >> fw) & fp_mask(ew);
  endfunction

  function automatic int unsigned fp_bias(input int unsigned ew);
    return (32'd1 << (ew - 32'd1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: positive, exponent all ones, only the fraction MSB set.
  function automatic fp_word_t fp_qnan(input int unsigned ew, input int unsigned fw);
    return (fp_mask(ew) << fw) | (fp_word_t'(1) << (fw - 32'd1));
  endfunction

  function automatic fp_word_t fp_inf(input logic s, input int unsigned ew,
                                      input int unsigned fw);
    return (fp_word_t'(s) << (ew + fw)) | (fp_mask(ew) << fw);
  endfunction

  function automatic fp_word_t fp_zero(input logic s, input int unsigned ew,
                                       input int unsigned fw);
    return fp_word_t'(s) << (ew + fw);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Decodes one operand into sign / zero / inf / NaN; subnormals count as zero.
module fp_classify
  import fp_pkg::*;
#(
  parameter int unsigned exp   = 8,
  parameter int unsigned frac  = 23,
  parameter int unsigned width = exp + frac + 1
) (
  input  logic [width-1:0] x_i,
  output logic             sign_c,
  output logic             is_zero_c,
  output logic             is_inf_c,
  output logic             is_nan_c
);

  logic [exp-1:0]  e_field;
  logic [frac-1:0] f_field;

  assign e_field   = exp'(fp_exp_of(fp_word_t'(x_i), exp, frac));
  assign f_field   = frac'(fp_frac_of(fp_word_t'(x_i), frac));
  assign sign_c    = x_i[width-1];
  assign is_zero_c = (e_field == '0);
  assign is_inf_c  = (e_field == '1) && (f_field == '0);
  assign is_nan_c  = (e_field == '1) && (f_field != '0);

endmodule

// File: rtl/fdiv_seq.sv
// Iterative restoring floating-point divider, one quotient bit per cycle,
// with valid/ready handshakes on operands and result.
module fdiv_seq
  import fp_pkg::*;
#(
  parameter int unsigned exp   = 8,
  parameter int unsigned frac  = 23,
  parameter int unsigned width = exp + frac + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] r,
  output logic [3:0]       flags
);

  localparam int unsigned N    = frac + 3;
  localparam int unsigned MW   = frac + 1;
  localparam int unsigned SW   = MW + 1;
  localparam int unsigned RW   = frac + 2;
  localparam int unsigned EW   = exp + 2;
  localparam int unsigned CW   = $clog2(N);
  localparam int unsigned BIAS = fp_bias(exp);
  localparam logic [CW-1:0]        LAST   = CW'(N - 1);
  localparam logic signed [EW-1:0] E_MAX  = EW'((32'd1 << exp) - 32'd1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  fdiv_state_e state_q, state_d;
  logic                 sign_q, sign_d;
  logic signed [EW-1:0] e_q, e_d;
  logic [MW-1:0]        mb_q, mb_d;
  logic [RW-1:0]        rem_q, rem_d;
  logic [N-1:0]         q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 rne_q, rne_d;
  logic                 special_q, special_d;
  logic [width-1:0]     sp_r_q, sp_r_d;
  logic [3:0]           sp_fl_q, sp_fl_d;
  logic [width-1:0]     r_q, r_d;
  logic [3:0]           flags_q, flags_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic sa, za, ia, na;
  logic sb, zb, ib, nb;

  fp_classify #(.exp(exp), .frac(frac)) u_cls_a (
    .x_i(a), .sign_c(sa), .is_zero_c(za), .is_inf_c(ia), .is_nan_c(na)
  );

  fp_classify #(.exp(exp), .frac(frac)) u_cls_b (
    .x_i(b), .sign_c(sb), .is_zero_c(zb), .is_inf_c(ib), .is_nan_c(nb)
  );

  logic [exp-1:0]  ea, eb;
  logic [frac-1:0] fa, fb;

  assign ea = exp'(fp_exp_of(fp_word_t'(a), exp, frac));
  assign eb = exp'(fp_exp_of(fp_word_t'(b), exp, frac));
  assign fa = frac'(fp_frac_of(fp_word_t'(a), frac));
  assign fb = frac'(fp_frac_of(fp_word_t'(b), frac));

  // Special-operand result, resolved at accept in priority order.
  logic             sgn_c, spec_c;
  logic [width-1:0] sp_r_c;
  logic [3:0]       sp_fl_c;

  always_comb begin
    sgn_c   = sa ^ sb;
    spec_c  = na | nb | za | zb | ia | ib;
    sp_r_c  = width'(fp_zero(sgn_c, exp, frac));
    sp_fl_c = '0;
    if (na || nb || (za && zb) || (ia && ib)) begin
      sp_r_c            = width'(fp_qnan(exp, frac));
      sp_fl_c[FLAG_INV] = 1'b1;
    end else if (zb && !ia) begin
      sp_r_c           = width'(fp_inf(sgn_c, exp, frac));
      sp_fl_c[FLAG_DZ] = 1'b1;
    end else if (ia) begin
      sp_r_c = width'(fp_inf(sgn_c, exp, frac));
    end
  end

  // Normalize, round and range-check the finished quotient.
  logic [MW-1:0]        mant_c;
  logic                 guard_c, sticky_c, inc_c;
  logic [SW-1:0]        sum_c;
  logic [frac-1:0]      frac_r_c;
  logic signed [EW-1:0] en_c, er_c;
  logic [width-1:0]     nr_c;
  logic [3:0]           nfl_c;

  always_comb begin
    sticky_c = |rem_q;
    if (q_q[N-1]) begin
      mant_c   = q_q[N-1:2];
      guard_c  = q_q[1];
      sticky_c = sticky_c | q_q[0];
      en_c     = e_q;
    end else begin
      mant_c  = q_q[N-2:1];
      guard_c = q_q[0];
      en_c    = e_q - EW'(1);
    end
    inc_c = rne_q & guard_c & (sticky_c | mant_c[0]);
    sum_c = {1'b0, mant_c} + SW'(inc_c);
    if (sum_c[MW]) begin
      frac_r_c = sum_c[frac:1];
      er_c     = en_c + EW'(1);
    end else begin
      frac_r_c = sum_c[frac-1:0];
      er_c     = en_c;
    end
    nfl_c = '0;
    nr_c  = {sign_q, er_c[exp-1:0], frac_r_c};
    if (er_c >= E_MAX) begin
      nr_c           = width'(fp_inf(sign_q, exp, frac));
      nfl_c[FLAG_OF] = 1'b1;
    end else if (er_c <= E_ZERO) begin
      nr_c           = width'(fp_zero(sign_q, exp, frac));
      nfl_c[FLAG_UF] = 1'b1;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    e_d       = e_q;
    mb_d      = mb_q;
    rem_d     = rem_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    rne_d     = rne_q;
    special_d = special_q;
    sp_r_d    = sp_r_q;
    sp_fl_d   = sp_fl_q;
    r_d       = r_q;
    flags_d   = flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d    = sgn_c;
          rne_d     = round_mode;
          special_d = spec_c;
          sp_r_d    = sp_r_c;
          sp_fl_d   = sp_fl_c;
          e_d       = EW'(ea) - EW'(eb) + EW'(BIAS);
          mb_d      = {1'b1, fb};
          rem_d     = {2'b01, fa};
          q_d       = '0;
          cnt_d     = '0;
          state_d   = spec_c ? ST_ROUND : ST_DIV;
        end
      end
      ST_DIV: begin
        if (rem_q >= {1'b0, mb_q}) begin
          rem_d = (rem_q - {1'b0, mb_q}) << 1;
          q_d   = {q_q[N-2:0], 1'b1};
        end else begin
          rem_d = rem_q << 1;
          q_d   = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        r_d     = special_q ? sp_r_q : nr_c;
        flags_d = special_q ? sp_fl_q : nfl_c;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      e_q         <= '0;
      mb_q        <= '0;
      rem_q       <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      rne_q       <= 1'b0;
      special_q   <= 1'b0;
      sp_r_q      <= '0;
      sp_fl_q     <= '0;
      r_q         <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      e_q         <= e_d;
      mb_q        <= mb_d;
      rem_q       <= rem_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      rne_q       <= rne_d;
      special_q   <= special_d;
      sp_r_q      <= sp_r_d;
      sp_fl_q     <= sp_fl_d;
      r_q         <= r_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: directed vector table, handshake corner
// sequences and random operands against an integer-division reference model.
module tb_fdiv_seq;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, round_mode, out_valid, out_ready;
  logic [31:0] a, b, r;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  fdiv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .round_mode(round_mode), .out_valid(out_valid),
    .out_ready(out_ready), .r(r), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic [31:0] r;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic tout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got no handshake, required one within budget", nm);
  endtask

  // Correctly rounded quotient from one wide integer division.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic rm,
                                  output logic [31:0] res, output logic [3:0] fl,
                                  output int lat);
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy;
    logic        s, zx, ix, nx, zy, iy, ny, g, st;
    logic [63:0] ma, mb, num, qi, rem, mant;
    int          e;
    ex = x[30:23]; fx = x[22:0]; ey = y[30:23]; fy = y[22:0];
    zx = (ex == 8'h00); ix = (ex == 8'hFF) && (fx == 0); nx = (ex == 8'hFF) && (fx != 0);
    zy = (ey == 8'h00); iy = (ey == 8'hFF) && (fy == 0); ny = (ey == 8'hFF) && (fy != 0);
    s = x[31] ^ y[31];
    fl = 4'b0000;
    lat = 2;
    if (nx || ny || (zx && zy) || (ix && iy)) begin
      res = 32'h7FC00000; fl = 4'b1000;
    end else if (zy && !ix) begin
      res = {s, 8'hFF, 23'h0}; fl = 4'b0100;
    end else if (ix) begin
      res = {s, 8'hFF, 23'h0};
    end else if (zx || iy) begin
      res = {s, 31'h0};
    end else begin
      lat = 28;
      ma = {40'h0, 1'b1, fx};
      mb = {40'h0, 1'b1, fy};
      num = ma << 26;
      qi = num / mb;
      rem = num % mb;
      e = int'(ex) - int'(ey) + 127;
      if (ma >= mb) begin
        mant = qi >> 3; g = qi[2]; st = (qi[1:0] != 0) || (rem != 0);
      end else begin
        mant = qi >> 2; g = qi[1]; st = qi[0] || (rem != 0); e = e - 1;
      end
      if (rm && g && (st || mant[0])) mant = mant + 1;
      if (mant == 64'h1000000) begin
        mant = mant >> 1; e = e + 1;
      end
      if (e >= 255) begin
        res = {s, 8'hFF, 23'h0}; fl = 4'b0010;
      end else if (e <= 0) begin
        res = {s, 31'h0}; fl = 4'b0001;
      end else begin
        res = {s, 8'(e), mant[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] gen_op();
    int          k;
    logic [7:0]  e;
    logic [22:0] f;
    k = int'($urandom_range(0, 15));
    f = 23'($urandom);
    if (k == 0) e = 8'h00;
    else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = '0;
    end else if (k < 4) e = 8'($urandom_range(1, 254));
    else e = 8'($urandom_range(100, 154));
    return {1'($urandom), e, f};
  endfunction

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic m,
                          output bit ok);
    int w = 0;
    ok = 1'b1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      tout("accept");
      ok = 1'b0;
      return;
    end
    in_valid = 1'b1; a = x; b = y; round_mode = m;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; round_mode = 1'($urandom);
  endtask

  task automatic wait_result(input int hold, output logic [31:0] rr, output logic [3:0] ff,
                             output int lat, output bit ok);
    ok = 1'b0; lat = 0; rr = '0; ff = '0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      tout("result");
      return;
    end
    rr = r; ff = flags;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    ok = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  localparam int NV = 16;

  initial begin
    vec_t        vecs [NV];
    logic [31:0] gr, er, x, y;
    logic [3:0]  gf, ef;
    int          gl, el, n;
    bit          ok, seen;
    logic        m;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 4'b0000, 28};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 1'b1, 32'h3EAAAAAB, 4'b0000, 28};
    vecs[2]  = '{32'h3F800000, 32'h40400000, 1'b0, 32'h3EAAAAAA, 4'b0000, 28};
    vecs[3]  = '{32'h3F800000, 32'h00000000, 1'b1, 32'h7F800000, 4'b0100, 2};
    vecs[4]  = '{32'h00000000, 32'h00000000, 1'b1, 32'h7FC00000, 4'b1000, 2};
    vecs[5]  = '{32'h7F7FFFFF, 32'h3F000000, 1'b1, 32'h7F800000, 4'b0010, 28};
    vecs[6]  = '{32'h7F7FFFFF, 32'h3F000000, 1'b0, 32'h7F800000, 4'b0010, 28};
    vecs[7]  = '{32'h00800000, 32'h40000000, 1'b1, 32'h00000000, 4'b0001, 28};
    vecs[8]  = '{32'h7F800000, 32'h40000000, 1'b1, 32'h7F800000, 4'b0000, 2};
    vecs[9]  = '{32'hBF800000, 32'h7F800000, 1'b1, 32'h80000000, 4'b0000, 2};
    vecs[10] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 2};
    vecs[11] = '{32'hFF800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2};
    vecs[12] = '{32'h80000000, 32'h40400000, 1'b1, 32'h80000000, 4'b0000, 2};
    vecs[13] = '{32'h00000001, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 2};
    vecs[14] = '{32'h3F800000, 32'h80400000, 1'b1, 32'hFF800000, 4'b0100, 2};
    vecs[15] = '{32'hC0C00000, 32'h40000000, 1'b1, 32'hC0400000, 4'b0000, 28};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; round_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_r", 64'(r), 64'(0));
    chk("reset_flags", 64'(flags), 64'(0));

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      start_op(vecs[i].a, vecs[i].b, vecs[i].rm, ok);
      if (ok) begin
        wait_result(0, gr, gf, gl, ok);
        if (ok) begin
          chk($sformatf("vec%0d_r", i), 64'(gr), 64'(vecs[i].r));
          chk($sformatf("vec%0d_flags", i), 64'(gf), 64'(vecs[i].fl));
          chk($sformatf("vec%0d_latency", i), 64'(gl), 64'(vecs[i].lat));
        end
      end
    end

    // Back-pressure in DONE, then back-to-back accept after release.
    @(negedge clk);
    start_op(32'h3F800000, 32'h40400000, 1'b1, ok);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) tout("hold_result");
    else begin
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("done_hold%0d", i), 64'({out_valid, in_ready, flags, r}),
            64'({1'b1, 1'b0, 4'h0, 32'h3EAAAAAB}));
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("release_idle", 64'({in_ready, out_valid}), 64'(2'b10));
      start_op(32'h40C00000, 32'h40000000, 1'b1, ok);
      if (ok) begin
        wait_result(0, gr, gf, gl, ok);
        if (ok) begin
          chk("b2b_r", 64'(gr), 64'(32'h40400000));
          chk("b2b_latency", 64'(gl), 64'(28));
        end
      end
    end

    // Reset in the middle of the iteration phase discards the operation.
    @(negedge clk);
    start_op(32'h40C00000, 32'h40000000, 1'b1, ok);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_result", 64'(seen), 64'(0));
    start_op(32'h40C00000, 32'h40000000, 1'b1, ok);
    if (ok) begin
      wait_result(1, gr, gf, gl, ok);
      if (ok) begin
        chk("after_abort_r", 64'(gr), 64'(32'h40400000));
        chk("after_abort_flags", 64'(gf), 64'(0));
        chk("after_abort_latency", 64'(gl), 64'(28));
      end
    end

    for (int i = 0; i < 300; i++) begin
      x = gen_op();
      y = gen_op();
      m = 1'($urandom);
      ref_div(x, y, m, er, ef, el);
      @(negedge clk);
      start_op(x, y, m, ok);
      if (ok) begin
        wait_result(int'($urandom_range(0, 2)), gr, gf, gl, ok);
        if (ok) begin
          chk($sformatf("rand%0d_r a=%h b=%h rm=%0d", i, x, y, m), 64'(gr), 64'(er));
          chk($sformatf("rand%0d_flags a=%h b=%h", i, x, y), 64'(gf), 64'(ef));
          chk($sformatf("rand%0d_latency", i), 64'(gl), 64'(el));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
